wb_port_arbiter: RTL and testbench

Two-master Wishbone arbiter that shares the user project's single Wishbone slave (register bank / SRAM behind the user wrapper) between the management SoC Wishbone port (master 0) and a local logic-analyzer-driven master (master 1). Round-robin grant, bus ownership held for the whole `cyc` envelope, and a watchdog that terminates stalled transfers with `err`. It sits inside the user project wrapper between the `wbs_*` pins and the slave.

---
 rtl/wb_port_arbiter.sv | 105 ++++++++++
 tb/tb_wb_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: two-master round-robin Wishbone arbiter with a stall watchdog
// Ports:
//   wb_clk_i, wb_rstn_i           clock, asynchronous active-low reset
//   mN_cyc/stb/we/sel/adr/dat_i   master N request (N = 0, 1)
//   mN_ack/err/dat_o              master N termination and read data
//   s_cyc/stb/we/sel/adr/dat_o    request to the shared slave
//   s_dat/ack/err_i               slave response
//   gnt_o                         one-hot owner {m1, m0}, 00 when idle
//   timeout_o                     one-cycle pulse when the watchdog aborts a transfer
module wb_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rstn_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  // a zero TIMEOUT would give a zero-width counter, so keep at least one bit
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  state_e        state_q;
  logic          last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          own0, own1, o_stb, term, abort;
  assign own0  = state_q == OWN0;
  assign own1  = state_q == OWN1;
  assign o_stb = own0 ? m0_stb_i : own1 & m1_stb_i;
  assign term  = s_ack_i | s_err_i;
  // a real termination in the abort cycle wins, so the watchdog only fires on a true stall
  assign abort = (TIMEOUT != 0) && o_stb && !term && (cnt_q == CW'(TIMEOUT));
  assign cnt_d = (!o_stb || term || abort) ? '0 : cnt_q + CW'(1);
  assign s_cyc_o   = own0 ? m0_cyc_i : own1 & m1_cyc_i;
  assign s_stb_o   = o_stb & ~abort;
  assign s_we_o    = own0 ? m0_we_i : own1 & m1_we_i;
  assign s_sel_o   = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
  assign s_adr_o   = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
  assign s_dat_o   = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
  assign m0_ack_o  = own0 & s_ack_i;
  assign m0_err_o  = own0 & (s_err_i | abort);
  assign m1_ack_o  = own1 & s_ack_i;
  assign m1_err_o  = own1 & (s_err_i | abort);
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign gnt_o     = {own1, own0};
  assign timeout_o = abort;
  // ownership lasts for the whole cyc envelope; on release the waiting master takes over
  // directly, and contention from idle goes to the master that did not own last
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) state_q <= OWN0;
          else if (m1_cyc_i) state_q <= OWN1;
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            last_q  <= 1'b0;
            state_q <= m1_cyc_i ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            last_q  <= 1'b1;
            state_q <= m0_cyc_i ? OWN0 : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rstn;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [31:0] s_dat_i;
  logic        s_ack, s_err;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, tmo;
  logic [31:0] m0_rd, m1_rd, s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we, z_tmo;
  logic [31:0] z_m0_rd, z_m1_rd, z_s_adr, z_s_dat_o;
  logic [3:0]  z_s_sel;
  logic [1:0]  z_gnt;
  int n_cmp = 0;
  int n_err = 0;

  wb_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rd),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rd),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(gnt), .timeout_o(tmo)
  );

  wb_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) dut0 (
    .wb_clk_i(clk), .wb_rstn_i(rstn),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err), .m0_dat_o(z_m0_rd),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err), .m1_dat_o(z_m1_rd),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_sel_o(z_s_sel), .s_adr_o(z_s_adr),
    .s_dat_o(z_s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .gnt_o(z_gnt), .timeout_o(z_tmo)
  );

  task automatic idle_bus();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat = '0;
    s_ack = 0; s_err = 0;
  endtask

  task automatic test_reset();
    idle_bus();
    s_dat_i = $urandom;
    rstn = 0;
    #12;
    n_cmp++;
    if ({gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o} !== 73'd0) begin
      n_err++; $display("FAIL reset_slave got %h exp 0", {gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o});
    end
    n_cmp++;
    if ({m0_ack, m0_err, m1_ack, m1_err, tmo} !== 5'b0) begin
      n_err++; $display("FAIL reset_term got %b exp 00000", {m0_ack, m0_err, m1_ack, m1_err, tmo});
    end
    n_cmp++;
    if ({m0_rd, m1_rd} !== {s_dat_i, s_dat_i}) begin
      n_err++; $display("FAIL reset_rdata got %h/%h exp %h", m0_rd, m1_rd, s_dat_i);
    end
    m0_cyc = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_hold_gnt got %b exp 00", gnt); end
    m0_cyc = 0;
    @(negedge clk); rstn = 1;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL reset_release_gnt got %b exp 00", gnt); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF; m0_adr = 32'h3000_0000; m0_dat = 32'hCAFE_F00D;
    #1;
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL wr_latency got %b exp 00", gnt); end
    @(negedge clk);
    n_cmp++;
    if ({gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o} !== {2'b01, 3'b111, 4'hF, 32'h3000_0000, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL wr_slave got %h exp %h", {gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o},
                        {2'b01, 3'b111, 4'hF, 32'h3000_0000, 32'hCAFE_F00D});
    end
    s_ack = 1; #1;
    n_cmp++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b1000) begin
      n_err++; $display("FAIL wr_ack got %b exp 1000", {m0_ack, m0_err, m1_ack, m1_err});
    end
    @(negedge clk); idle_bus(); #1;
    n_cmp++;
    if (m0_ack !== 1'b0) begin n_err++; $display("FAIL wr_ack_drop got %b exp 0", m0_ack); end
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL wr_idle got %b exp 00", gnt); end
  endtask

  task automatic test_contention();
    logic [31:0] a0, a1;
    a0 = $urandom; a1 = $urandom;
    rstn = 0;
    @(negedge clk); rstn = 1;
    m0_cyc = 1; m0_stb = 1; m0_adr = a0;
    m1_cyc = 1; m1_stb = 1; m1_adr = a1;
    @(negedge clk);
    n_cmp++;
    if ({gnt, s_adr} !== {2'b01, a0}) begin n_err++; $display("FAIL cont_first got %b/%h exp 01/%h", gnt, s_adr, a0); end
    s_ack = 1; #1;
    n_cmp++;
    if ({m0_ack, m1_ack} !== 2'b10) begin n_err++; $display("FAIL cont_ack0 got %b exp 10", {m0_ack, m1_ack}); end
    @(negedge clk); m0_cyc = 0; m0_stb = 0; s_ack = 0; #1;
    n_cmp++;
    if ({gnt, s_cyc} !== 3'b010) begin n_err++; $display("FAIL cont_release got %b exp 010", {gnt, s_cyc}); end
    @(negedge clk);
    n_cmp++;
    if ({gnt, s_cyc, s_adr} !== {3'b101, a1}) begin
      n_err++; $display("FAIL cont_handover got %b/%h exp 101/%h", {gnt, s_cyc}, s_adr, a1);
    end
    s_ack = 1; #1;
    n_cmp++;
    if ({m0_ack, m1_ack} !== 2'b01) begin n_err++; $display("FAIL cont_ack1 got %b exp 01", {m0_ack, m1_ack}); end
    @(negedge clk); m1_cyc = 0; m1_stb = 0; s_ack = 0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL cont_idle got %b exp 00", gnt); end
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL cont_second got %b exp 01", gnt); end
    idle_bus();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_block();
    logic [31:0] base, ea;
    base = $urandom & 32'hFFFF_FF00;
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_adr = base;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b10) begin n_err++; $display("FAIL blk_grant got %b exp 10", gnt); end
    for (int i = 0; i < 4; i++) begin
      ea = base + 32'(4 * i);
      m1_adr = ea; s_dat_i = $urandom; s_ack = 1;
      if (i == 1) begin m0_cyc = 1; m0_stb = 1; m0_adr = 32'hDEAD_0000; end
      #1;
      n_cmp++;
      if ({gnt, s_adr, m1_ack, m0_ack, m1_rd} !== {2'b10, ea, 2'b10, s_dat_i}) begin
        n_err++; $display("FAIL blk_beat%0d got %b/%h/%b%b/%h exp 10/%h/10/%h", i, gnt, s_adr, m1_ack, m0_ack, m1_rd, ea, s_dat_i);
      end
      @(negedge clk);
    end
    m1_cyc = 0; m1_stb = 0; s_ack = 0; #1;
    n_cmp++;
    if ({gnt, m0_ack} !== 3'b100) begin n_err++; $display("FAIL blk_tail got %b exp 100", {gnt, m0_ack}); end
    @(negedge clk);
    n_cmp++;
    if ({gnt, s_adr} !== {2'b01, 32'hDEAD_0000}) begin n_err++; $display("FAIL blk_m0_after got %b/%h exp 01/dead0000", gnt, s_adr); end
    s_ack = 1; #1;
    n_cmp++;
    if (m0_ack !== 1'b1) begin n_err++; $display("FAIL blk_m0_ack got %b exp 1", m0_ack); end
    @(negedge clk); idle_bus();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom;
    @(negedge clk);
    for (int i = 0; i <= 8; i++) begin
      #1;
      n_cmp++;
      if ({m0_err, tmo, s_stb, z_m0_err, z_tmo} !== ((i == 8) ? 5'b11000 : 5'b00100)) begin
        n_err++; $display("FAIL tmo_cycle%0d got %b exp %b", i, {m0_err, tmo, s_stb, z_m0_err, z_tmo}, (i == 8) ? 5'b11000 : 5'b00100);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({m0_err, tmo, s_stb} !== 3'b001) begin n_err++; $display("FAIL tmo_after got %b exp 001", {m0_err, tmo, s_stb}); end
    idle_bus();
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b00) begin n_err++; $display("FAIL tmo_idle got %b exp 00", gnt); end
  endtask

  task automatic test_no_timeout();
    int zbad, pulses;
    zbad = 0; pulses = 0;
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom;
    @(negedge clk);
    repeat (1000) begin
      #1;
      if (z_m0_err || z_tmo) zbad++;
      if (tmo) pulses++;
      @(negedge clk);
    end
    n_cmp++;
    if (zbad !== 0) begin n_err++; $display("FAIL notmo_err got %0d exp 0", zbad); end
    n_cmp++;
    if (pulses !== ((1000 - 1 - 8) / 9) + 1) begin
      n_err++; $display("FAIL tmo_repeat got %0d exp %0d", pulses, ((1000 - 1 - 8) / 9) + 1);
    end
    s_ack = 1; #1;
    n_cmp++;
    if ({z_m0_ack, z_m0_err} !== 2'b10) begin n_err++; $display("FAIL notmo_ack got %b exp 10", {z_m0_ack, z_m0_err}); end
    @(negedge clk); idle_bus();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'h3; m1_adr = $urandom; m1_dat = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({gnt, s_cyc, s_we} !== 4'b1011) begin n_err++; $display("FAIL rstmid_grant got %b exp 1011", {gnt, s_cyc, s_we}); end
    #2; s_ack = 1; rstn = 0; #1;
    n_cmp++;
    if ({gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, m1_ack, m0_ack} !== 75'd0) begin
      n_err++; $display("FAIL rstmid_clear got %h exp 0", {gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, m1_ack, m0_ack});
    end
    @(negedge clk);
    rstn = 1; s_ack = 0; m0_cyc = 1; m0_stb = 1;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 2'b01) begin n_err++; $display("FAIL rstmid_regrant got %b exp 01", gnt); end
    idle_bus();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_random();
    int owner, last, w;
    logic ostb, abort;
    logic [77:0] got, exp;
    idle_bus();
    rstn = 0;
    @(negedge clk); rstn = 1;
    owner = -1; last = 1; w = 0;
    for (int c = 0; c < 600; c++) begin
      if (!m0_cyc) m0_cyc = ($urandom_range(2) == 0);
      else if ($urandom_range(3) == 0) m0_cyc = 0;
      if (!m1_cyc) m1_cyc = ($urandom_range(2) == 0);
      else if ($urandom_range(3) == 0) m1_cyc = 0;
      m0_stb = m0_cyc & ($urandom_range(3) != 0);
      m1_stb = m1_cyc & ($urandom_range(3) != 0);
      m0_we = $urandom; m0_sel = $urandom; m0_adr = $urandom; m0_dat = $urandom;
      m1_we = $urandom; m1_sel = $urandom; m1_adr = $urandom; m1_dat = $urandom;
      s_ack = ($urandom_range(3) == 0);
      s_err = !s_ack && ($urandom_range(9) == 0);
      s_dat_i = $urandom;
      #1;
      ostb  = (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
      abort = ostb && !s_ack && !s_err && (w == 8);
      exp = {(owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00,
             (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0,
             ostb && !abort,
             (owner == 0) ? m0_we : (owner == 1) ? m1_we : 1'b0,
             (owner == 0) ? m0_sel : (owner == 1) ? m1_sel : 4'h0,
             (owner == 0) ? m0_adr : (owner == 1) ? m1_adr : 32'h0,
             (owner == 0) ? m0_dat : (owner == 1) ? m1_dat : 32'h0,
             (owner == 0) && s_ack, (owner == 0) && (s_err || abort),
             (owner == 1) && s_ack, (owner == 1) && (s_err || abort), abort};
      got = {gnt, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o, m0_ack, m0_err, m1_ack, m1_err, tmo};
      n_cmp++;
      if (got !== exp || m0_rd !== s_dat_i || m1_rd !== s_dat_i) begin
        n_err++; $display("FAIL rand_cycle%0d got %h exp %h", c, got, exp);
      end
      w = (ostb && !s_ack && !s_err && !abort) ? w + 1 : 0;
      if (owner < 0) begin
        if (m0_cyc && m1_cyc) owner = 1 - last;
        else if (m0_cyc) owner = 0;
        else if (m1_cyc) owner = 1;
      end else if (!((owner == 0) ? m0_cyc : m1_cyc)) begin
        last  = owner;
        owner = ((owner == 0) ? m1_cyc : m0_cyc) ? 1 - owner : -1;
      end
      @(negedge clk);
    end
    idle_bus();
  endtask

  initial begin
    rstn = 0;
    s_dat_i = '0;
    idle_bus();
    test_reset();
    test_single_write();
    test_contention();
    test_block();
    test_timeout();
    test_no_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
